// File: rtl/vend_pkg.sv
// Shared types and constants for the vending dispense-side controller.
package vend_pkg;

   localparam int PROD_W    = 3;
   localparam int NUM_SLOTS = 8;

   localparam logic [PROD_W-1:0] NO_PRODUCT = 3'd0;

   typedef enum logic [2:0] {
      IDLE,
      RUN,
      WAIT_DROP,
      DONE,
      FAULT
   } vend_state_t;

   // Larger of two integers, used to size counters shared between phases.
   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/vend_sync_edge.sv
// Two-flop synchronizer followed by a rising-edge detector for raw
// mechanical inputs. The flops hold while ena is low so no edge is lost.
module vend_sync_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic ena,
   input  logic raw_in,
   output logic rise_pulse
);

   logic [1:0] sync_q;
   logic       prev_q;

   // Shift the raw input through the synchronizer and keep the last synced value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= 2'b00;
         prev_q <= 1'b0;
      end else if (ena) begin
         sync_q <= {sync_q[0], raw_in};
         prev_q <= sync_q[1];
      end
   end

   assign rise_pulse = sync_q[1] & ~prev_q;

endmodule

// File: rtl/vend_dispenser_ctrl.sv
// Dispense controller: drives the selected slot motor for a fixed time,
// then waits for the drop sensor, reporting completion or a jam fault.
module vend_dispenser_ctrl
   import vend_pkg::*;
#(
   parameter int MOTOR_CYCLES   = 16,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 ena,
   input  logic                 disp_req,
   input  logic [PROD_W-1:0]    prod_code,
   input  logic                 drop_sensor,
   input  logic                 fault_clr,
   output logic [NUM_SLOTS-1:0] motor_en,
   output logic                 busy,
   output logic                 done,
   output logic                 fault,
   output logic [7:0]           vend_count
);

   // One counter serves both the motor run and the drop timeout.
   localparam int CNT_MAX = max_int(MOTOR_CYCLES, TIMEOUT_CYCLES);
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   localparam logic [CNT_W-1:0] MOTOR_LOAD   = CNT_W'(MOTOR_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

   vend_state_t       state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [PROD_W-1:0] slot_q, slot_d;
   logic              dropped_q, dropped_d;
   logic [7:0]        count_d;
   logic              drop_edge;

   vend_sync_edge u_drop_sync (
      .clk        (clk),
      .rst_n      (rst_n),
      .ena        (ena),
      .raw_in     (drop_sensor),
      .rise_pulse (drop_edge)
   );

   // State register; everything freezes while ena is low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         slot_q     <= NO_PRODUCT;
         dropped_q  <= 1'b0;
         vend_count <= 8'd0;
      end else if (ena) begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         slot_q     <= slot_d;
         dropped_q  <= dropped_d;
         vend_count <= count_d;
      end
   end

   // Next-state logic; a drop edge beats timeout expiry in the same cycle.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      slot_d    = slot_q;
      dropped_d = dropped_q;
      count_d   = vend_count;
      unique case (state_q)
         IDLE: begin
            if (disp_req && (prod_code != NO_PRODUCT)) begin
               slot_d  = prod_code;
               cnt_d   = MOTOR_LOAD;
               state_d = RUN;
            end
         end
         RUN: begin
            if (drop_edge) begin
               dropped_d = 1'b1;
            end
            if (cnt_q == '0) begin
               if (dropped_q || drop_edge) begin
                  state_d = DONE;
               end else begin
                  state_d = WAIT_DROP;
                  cnt_d   = TIMEOUT_LOAD;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         WAIT_DROP: begin
            if (drop_edge) begin
               state_d = DONE;
            end else if (cnt_q == '0) begin
               state_d = FAULT;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         DONE: begin
            count_d   = vend_count + 8'd1;
            dropped_d = 1'b0;
            state_d   = IDLE;
         end
         FAULT: begin
            if (fault_clr) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Motor drive decoded from registered state only: one-hot on the latched slot.
   always_comb begin
      motor_en = '0;
      if (state_q == RUN) begin
         motor_en[slot_q] = 1'b1;
      end
   end

   assign busy  = (state_q != IDLE);
   assign done  = (state_q == DONE);
   assign fault = (state_q == FAULT);

endmodule
